five_in_row_checker: RTL and testbench
======================================

Name: five_in_row_checker

Overview:
Reads the 512-bit game board produced by the board writer and scans it sequentially for five same-colour stones in a line. It is the read side of the board interface: the writer places stones, this block reports whether and where a player has won. The game controller pulses start after each placed move and uses winner and done to update gaming_status.

Parameters:
BOARD_W, 16, board columns (x range 0..BOARD_W-1)
BOARD_H, 16, board rows (y range 0..BOARD_H-1)
CELL_BITS, 2, bits per cell
WIN_LEN, 5, stones in a row required to win

Ports:
Clck  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
board  input  BOARD_W*BOARD_H*CELL_BITS (512)  board state; cell (x,y) at bit offset x*2 + y*32, width 2
start  input  1  request a scan; sampled only in IDLE
busy  output  1  high while scanning
done  output  1  one-cycle pulse when a scan finishes
winner  output  2  00 none, 01 player 1, 10 player 2
win_x  output  4  x of first stone of the winning line
win_y  output  4  y of first stone of the winning line
win_dir  output  2  0 horizontal (+x), 1 vertical (+y), 2 diagonal (+x,+y), 3 anti-diagonal (-x,+y)

Behaviour:
- Cell encoding: 00 empty, 01 player 1, 10 player 2, 11 treated as empty; it never matches.
- Reset (async, immediate): state IDLE, busy=0, done=0, winner=00, win_x=0, win_y=0, win_dir=0, index=0. Reset mid-scan aborts the scan with no done pulse.
- States: IDLE, SCAN, DONE.
- IDLE: at a clock edge with start=1, copy board into an internal snapshot, set index=0, go to SCAN, busy=1, clear winner, win_x, win_y and win_dir to 0.
- SCAN: each cycle, evaluate cell index i (x=i[3:0], y=i[7:4]; y outer, x inner) in all 4 directions using the snapshot only. Board changes during a scan are ignored.
- A line matches when the anchor cell is 01 or 10 and the next WIN_LEN-1 cells in that direction have the same value.
- Bounds per direction: dir0 needs x<=11; dir1 needs y<=11; dir2 needs x<=11 and y<=11; dir3 needs x>=4 and y<=11. Out-of-bounds directions never match. There is no row or column wrap-around.
- Several directions matching at one anchor: the lowest dir code wins. The first matching anchor in scan order wins; the scan stops there.
- On a match at index i: at that edge register winner, win_x, win_y and win_dir, then go to DONE. done is high in the cycle after the edge that evaluated i, i.e. i+1 cycles after the start edge.
- No match: after index 255 is evaluated, go to DONE with winner=00. done is high 256 cycles after the start edge.
- DONE: lasts one cycle with done=1 and busy=0, then returns to IDLE. A start seen in DONE is ignored.
- start while busy or in DONE: ignored, with no queuing.
- Result outputs hold their values from DONE until the next accepted start.
- index is 8 bits and reaches 255 without overflow logic, since the scan ends there.

Decomposition:
- Shared package fivesons_pkg holds:
  - cell constants CELL_EMPTY, CELL_P1 and CELL_P2;
  - direction codes DIR_H, DIR_V, DIR_D and DIR_A;
  - a cell-offset function (x*2 + y*32), shared with the board writer and renderer.
- Sub-module line_match: combinational. It takes the snapshot, anchor x/y and a direction code, and returns match plus colour. It is instantiated 4 times, once per direction.
- The FSM, snapshot register and result registers stay in five_in_row_checker.

Test Plan:
- Empty board, start pulse -> busy high for 256 cycles; done 256 cycles after the start edge; winner=00.
- Player 1 at (2..6, 3), start -> done 51 cycles after start; winner=01, win_x=2, win_y=3, win_dir=0.
- Player 2 at (4,0),(3,1),(2,2),(1,3),(0,4), start -> done 5 cycles after start; winner=10, win_x=4, win_y=0, win_dir=3.
- Player 1 at (13,0),(14,0),(15,0),(0,1),(1,1), plus a vertical four at x=7, y=0..3 -> no wrap-around and four is not enough; done at 256 cycles, winner=00.
- Start, then at cycle 10 write a horizontal five into the board and pulse start again -> second start ignored, result winner=00. A new start after done -> winner=01.
- Reset asserted at cycle 100 of a scan -> busy, done, winner and win_* all 0 immediately with no done pulse. After release, a start scans normally.

Source files
------------

// File: rtl/fivesons_pkg.sv
// fivesons_pkg: shared board geometry, cell/direction encodings, FSM state
// type and the cell bit-offset helper used by the board writer, renderer and
// the five-in-a-row checker.
package fivesons_pkg;

  localparam int BOARD_W    = 16;
  localparam int BOARD_H    = 16;
  localparam int CELL_BITS  = 2;
  localparam int WIN_LEN    = 5;
  localparam int ROW_BITS   = BOARD_W * CELL_BITS;
  localparam int BOARD_BITS = BOARD_W * BOARD_H * CELL_BITS;

  // Last anchor column/row from which a forward line of WIN_LEN still fits,
  // and first anchor column from which a backward (-x) line fits.
  localparam logic [3:0] MAX_FWD_X  = 4'(BOARD_W - WIN_LEN);
  localparam logic [3:0] MAX_FWD_Y  = 4'(BOARD_H - WIN_LEN);
  localparam logic [3:0] MIN_BACK_X = 4'(WIN_LEN - 1);

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  localparam logic [1:0] DIR_H = 2'd0;  // +x
  localparam logic [1:0] DIR_V = 2'd1;  // +y
  localparam logic [1:0] DIR_D = 2'd2;  // +x,+y
  localparam logic [1:0] DIR_A = 2'd3;  // -x,+y

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bit offset of cell (x,y) inside the flat board vector.
  function automatic logic [8:0] cell_offset(input logic [3:0] x, input logic [3:0] y);
    return 9'(x) * 9'(CELL_BITS) + 9'(y) * 9'(ROW_BITS);
  endfunction

endpackage

// File: rtl/five_in_row_checker_line_match.sv
// line_match: combinational test of one direction at one anchor.
// Ports:
//   board  - board snapshot (cell (x,y) at x*2 + y*32)
//   x, y   - anchor coordinates
//   dir    - direction code (DIR_H/V/D/A)
//   match  - anchor holds a player stone and the next WIN_LEN-1 cells agree
//   colour - colour of the matching line, CELL_EMPTY when no match
module line_match
  import fivesons_pkg::*;
(
  input  logic [BOARD_BITS-1:0] board,
  input  logic [3:0]            x,
  input  logic [3:0]            y,
  input  logic [1:0]            dir,
  output logic                  match,
  output logic [1:0]            colour
);

  logic       in_bounds_s;
  logic [1:0] anchor_s;
  logic [3:0] cx_s;
  logic [3:0] cy_s;
  logic       all_same_s;

  // Bounds gate: out-of-range lines are rejected here, so the 4-bit
  // coordinate arithmetic below may wrap harmlessly.
  always_comb begin
    in_bounds_s = 1'b0;
    case (dir)
      DIR_H:   in_bounds_s = (x <= MAX_FWD_X);
      DIR_V:   in_bounds_s = (y <= MAX_FWD_Y);
      DIR_D:   in_bounds_s = (x <= MAX_FWD_X) && (y <= MAX_FWD_Y);
      DIR_A:   in_bounds_s = (x >= MIN_BACK_X) && (y <= MAX_FWD_Y);
      default: in_bounds_s = 1'b0;
    endcase
  end

  // Walk the WIN_LEN-1 cells after the anchor and require each to equal it.
  always_comb begin
    anchor_s   = board[cell_offset(x, y) +: 2];
    all_same_s = in_bounds_s && ((anchor_s == CELL_P1) || (anchor_s == CELL_P2));
    cx_s       = x;
    cy_s       = y;
    for (int k = 1; k < WIN_LEN; k++) begin
      case (dir)
        DIR_H: begin cx_s = x + 4'(k); cy_s = y;          end
        DIR_V: begin cx_s = x;          cy_s = y + 4'(k); end
        DIR_D: begin cx_s = x + 4'(k); cy_s = y + 4'(k); end
        DIR_A: begin cx_s = x - 4'(k); cy_s = y + 4'(k); end
        default: begin cx_s = x;        cy_s = y;          end
      endcase
      all_same_s = all_same_s && (board[cell_offset(cx_s, cy_s) +: 2] == anchor_s);
    end
  end

  // Drive the result pair.
  always_comb begin
    match = all_same_s;
    if (all_same_s) begin
      colour = anchor_s;
    end else begin
      colour = CELL_EMPTY;
    end
  end

endmodule

// File: rtl/five_in_row_checker.sv
// five_in_row_checker: snapshots the board on start and scans every anchor
// (y outer, x inner), one per cycle, for five same-colour stones in a line.
// Ports:
//   Clck    - system clock, rising edge
//   Reset   - asynchronous active-high reset
//   board   - live board from the writer (512 bits)
//   start   - scan request, honoured only in IDLE
//   busy    - high while scanning
//   done    - one-cycle pulse when a scan finishes
//   winner  - 00 none, 01 player 1, 10 player 2
//   win_x   - x of first stone of the winning line
//   win_y   - y of first stone of the winning line
//   win_dir - 0 +x, 1 +y, 2 +x+y, 3 -x+y
module five_in_row_checker
  import fivesons_pkg::*;
(
  input  logic                  Clck,
  input  logic                  Reset,
  input  logic [BOARD_BITS-1:0] board,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            winner,
  output logic [3:0]            win_x,
  output logic [3:0]            win_y,
  output logic [1:0]            win_dir
);

  state_e                state_q, state_d;
  logic [BOARD_BITS-1:0] snap_q, snap_d;
  logic [7:0]            idx_q, idx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [1:0]            winner_q, winner_d;
  logic [3:0]            win_x_q, win_x_d;
  logic [3:0]            win_y_q, win_y_d;
  logic [1:0]            win_dir_q, win_dir_d;

  logic [3:0] lm_match_s;
  logic [1:0] lm_colour_s [4];
  logic       hit_s;
  logic [1:0] hit_dir_s;
  logic [1:0] hit_colour_s;

  // One matcher per direction, all looking at the current anchor.
  for (genvar d = 0; d < 4; d++) begin : g_dir
    line_match u_line_match (
      .board  (snap_q),
      .x      (idx_q[3:0]),
      .y      (idx_q[7:4]),
      .dir    (2'(d)),
      .match  (lm_match_s[d]),
      .colour (lm_colour_s[d])
    );
  end

  // Lowest direction code wins when several lines start at the same anchor.
  always_comb begin
    hit_s        = 1'b0;
    hit_dir_s    = DIR_H;
    hit_colour_s = CELL_EMPTY;
    if (lm_match_s[0]) begin
      hit_s = 1'b1; hit_dir_s = DIR_H; hit_colour_s = lm_colour_s[0];
    end else if (lm_match_s[1]) begin
      hit_s = 1'b1; hit_dir_s = DIR_V; hit_colour_s = lm_colour_s[1];
    end else if (lm_match_s[2]) begin
      hit_s = 1'b1; hit_dir_s = DIR_D; hit_colour_s = lm_colour_s[2];
    end else if (lm_match_s[3]) begin
      hit_s = 1'b1; hit_dir_s = DIR_A; hit_colour_s = lm_colour_s[3];
    end else begin
      hit_s = 1'b0;
    end
  end

  // Scan FSM next-state and result logic.
  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    winner_d  = winner_q;
    win_x_d   = win_x_q;
    win_y_d   = win_y_q;
    win_dir_d = win_dir_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          snap_d    = board;
          idx_d     = 8'd0;
          state_d   = ST_SCAN;
          busy_d    = 1'b1;
          winner_d  = CELL_EMPTY;
          win_x_d   = 4'd0;
          win_y_d   = 4'd0;
          win_dir_d = DIR_H;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (hit_s) begin
          winner_d  = hit_colour_s;
          win_x_d   = idx_q[3:0];
          win_y_d   = idx_q[7:4];
          win_dir_d = hit_dir_s;
          state_d   = ST_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end else if (idx_q == 8'd255) begin
          // Last anchor evaluated without a match; results stay cleared.
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State, snapshot and registered outputs.
  always_ff @(posedge Clck or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      snap_q    <= '0;
      idx_q     <= 8'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      winner_q  <= CELL_EMPTY;
      win_x_q   <= 4'd0;
      win_y_q   <= 4'd0;
      win_dir_q <= DIR_H;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      winner_q  <= winner_d;
      win_x_q   <= win_x_d;
      win_y_q   <= win_y_d;
      win_dir_q <= win_dir_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign winner  = winner_q;
  assign win_x   = win_x_q;
  assign win_y   = win_y_q;
  assign win_dir = win_dir_q;

endmodule

// File: tb/tb_five_in_row_checker.sv
// tb_five_in_row_checker: directed scans checked every cycle against a
// board-search model plus hand-computed latency/result expectations.
module tb_five_in_row_checker;
  import fivesons_pkg::*;

  logic         Clck = 1'b0;
  logic         Reset = 1'b0;
  logic         start = 1'b0;
  logic [511:0] board = '0;
  logic         busy, done;
  logic [1:0]   winner, win_dir;
  logic [3:0]   win_x, win_y;

  five_in_row_checker dut (
    .Clck(Clck), .Reset(Reset), .board(board), .start(start),
    .busy(busy), .done(done), .winner(winner),
    .win_x(win_x), .win_y(win_y), .win_dir(win_dir)
  );

  always #5 Clck = ~Clck;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  typedef struct packed {
    logic [8:0] idx;  // anchor index of the win, 255 when there is none
    logic [1:0] w;
    logic [3:0] x;
    logic [3:0] y;
    logic [1:0] d;
  } res_t;

  function automatic logic [1:0] cell_at(input logic [511:0] b, input int x, input int y);
    return b[x*2 + y*32 +: 2];
  endfunction

  // Plain search: first anchor in scan order, lowest direction, all five
  // cells on the board and holding the same player colour.
  function automatic res_t find_win(input logic [511:0] b);
    int dxs[4] = '{1, 0, 1, -1};
    int dys[4] = '{0, 1, 1, 1};
    res_t r;
    r = '{idx: 9'd255, w: 2'b00, x: 4'd0, y: 4'd0, d: 2'd0};
    for (int i = 0; i < 256; i++) begin
      for (int d = 0; d < 4; d++) begin
        int x0 = i % 16;
        int y0 = i / 16;
        int xe = x0 + 4 * dxs[d];
        int ye = y0 + 4 * dys[d];
        logic [1:0] c;
        bit ok;
        if (xe < 0 || xe > 15 || ye > 15) continue;
        c  = cell_at(b, x0, y0);
        ok = (c == 2'b01) || (c == 2'b10);
        for (int k = 1; k < 5; k++)
          if (cell_at(b, x0 + k * dxs[d], y0 + k * dys[d]) != c) ok = 1'b0;
        if (ok) begin
          r.idx = 9'(i); r.w = c; r.x = 4'(x0); r.y = 4'(y0); r.d = 2'(d);
          return r;
        end
      end
    end
    return r;
  endfunction

  // Cycle model: a scan takes (win index + 1) cycles; results appear with done.
  int         m_phase = 0;
  int         m_cnt   = 0;
  res_t       m_res   = '0;
  logic       e_busy = 1'b0, e_done = 1'b0;
  logic [1:0] e_w = 2'b00, e_d = 2'b00;
  logic [3:0] e_x = 4'd0, e_y = 4'd0;

  always @(posedge Clck or posedge Reset) begin
    if (Reset) begin
      m_phase <= 0; m_cnt <= 0; e_busy <= 1'b0; e_done <= 1'b0;
      e_w <= 2'b00; e_x <= 4'd0; e_y <= 4'd0; e_d <= 2'b00;
    end else begin
      case (m_phase)
        0: begin
          e_done <= 1'b0;
          if (start) begin
            m_res <= find_win(board); m_cnt <= 0; m_phase <= 1; e_busy <= 1'b1;
            e_w <= 2'b00; e_x <= 4'd0; e_y <= 4'd0; e_d <= 2'b00;
          end
        end
        1: begin
          m_cnt <= m_cnt + 1;
          if (m_cnt + 1 == int'(m_res.idx) + 1) begin
            m_phase <= 2; e_busy <= 1'b0; e_done <= 1'b1;
            e_w <= m_res.w; e_x <= m_res.x; e_y <= m_res.y; e_d <= m_res.d;
          end
        end
        default: begin m_phase <= 0; e_done <= 1'b0; end
      endcase
    end
  end

  // Per-cycle compare against the model.
  always @(negedge Clck) begin
    if (cmp_en) begin
      n_tests++;
      if ({busy, done, winner, win_x, win_y, win_dir} !== {e_busy, e_done, e_w, e_x, e_y, e_d}) begin
        n_fail++;
        $display("FAIL cycle_model t=%0t: got busy=%b done=%b w=%b x=%0d y=%0d d=%0d, expected busy=%b done=%b w=%b x=%0d y=%0d d=%0d",
                 $time, busy, done, winner, win_x, win_y, win_dir, e_busy, e_done, e_w, e_x, e_y, e_d);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic put_line(input int x0, input int y0, input int dx, input int dy,
                          input int n, input logic [1:0] v);
    for (int k = 0; k < n; k++) board[(x0 + k*dx)*2 + (y0 + k*dy)*32 +: 2] = v;
  endtask

  task automatic wait_idle();
    int guard = 0;
    @(negedge Clck);
    while ((busy || done) && guard < 400) begin @(negedge Clck); guard++; end
    if (guard >= 400) check("wait_idle_timeout", 1, 0);
  endtask

  // Pulse start from IDLE and check latency and result against literals.
  task automatic run(input string name, input int lat_exp, input int w, input int x,
                     input int y, input int d);
    int lat = 0;
    bit got = 1'b0;
    wait_idle();
    start = 1'b1;
    @(posedge Clck); #1 start = 1'b0;
    while (!got && lat < 300) begin
      @(posedge Clck); #1; lat++;
      if (done) got = 1'b1;
    end
    check({name, "_done_seen"}, int'(got), 1);
    check({name, "_latency"}, lat, lat_exp);
    check({name, "_winner"}, int'(winner), w);
    check({name, "_x"}, int'(win_x), x);
    check({name, "_y"}, int'(win_y), y);
    check({name, "_dir"}, int'(win_dir), d);
  endtask

  initial begin
    int lat;
    bit got;
    res_t pin;

    #3 Reset = 1'b1;
    cmp_en = 1'b1;
    repeat (2) @(negedge Clck);
    check("reset_outputs", int'({busy, done, winner, win_x, win_y, win_dir}), 0);
    Reset = 1'b0;

    // Model pins
    board = '0; put_line(2, 3, 1, 0, 5, 2'b01);
    pin = find_win(board);
    check("model_pin_idx", int'(pin.idx), 50);
    board = '0; put_line(1, 1, 1, 0, 4, 2'b10);
    pin = find_win(board);
    check("model_pin_none", int'(pin.w), 0);

    board = '0;
    run("empty", 256, 0, 0, 0, 0);

    // start seen in DONE is ignored
    start = 1'b1;
    @(posedge Clck); #1 start = 1'b0;
    @(posedge Clck); #1;
    check("start_in_done_ignored", int'(busy), 0);

    board = '0; put_line(2, 3, 1, 0, 5, 2'b01);
    run("p1_horiz", 51, 1, 2, 3, 0);

    board = '0; put_line(4, 0, -1, 1, 5, 2'b10);
    run("p2_anti", 5, 2, 4, 0, 3);

    board = '0;
    put_line(13, 0, 1, 0, 3, 2'b01); put_line(0, 1, 1, 0, 2, 2'b01);
    put_line(7, 0, 0, 1, 4, 2'b01);
    run("no_wrap_four", 256, 0, 0, 0, 0);

    board = '0;
    put_line(0, 0, 1, 0, 5, 2'b01); put_line(0, 0, 0, 1, 5, 2'b01);
    put_line(0, 0, 1, 1, 5, 2'b01);
    run("multi_dir", 1, 1, 0, 0, 0);

    board = '0; put_line(11, 11, 1, 1, 5, 2'b10);
    run("diag_corner", 188, 2, 11, 11, 2);

    board = '0; put_line(0, 5, 1, 0, 5, 2'b11);
    run("cell_11", 256, 0, 0, 0, 0);

    // Board change plus start during a scan are both ignored.
    board = '0;
    wait_idle();
    start = 1'b1;
    @(posedge Clck); #1 start = 1'b0;
    lat = 0; got = 1'b0;
    while (!got && lat < 300) begin
      @(posedge Clck); #1; lat++;
      if (lat == 10) begin put_line(2, 3, 1, 0, 5, 2'b01); start = 1'b1; end
      if (lat == 11) start = 1'b0;
      if (done) got = 1'b1;
    end
    check("midscan_latency", lat, 256);
    check("midscan_winner", int'(winner), 0);
    run("after_midscan", 51, 1, 2, 3, 0);

    // Reset in the middle of a scan
    board = '0;
    wait_idle();
    start = 1'b1;
    @(posedge Clck); #1 start = 1'b0;
    repeat (99) @(posedge Clck);
    #2 Reset = 1'b1;
    #1 check("midscan_reset_outputs", int'({busy, done, winner, win_x, win_y, win_dir}), 0);
    repeat (3) @(negedge Clck);
    Reset = 1'b0;
    board = '0; put_line(2, 3, 1, 0, 5, 2'b01);
    run("after_reset", 51, 1, 2, 3, 0);

    repeat (3) @(negedge Clck);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
